// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with one outstanding request, redirect and timeout
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        fetch_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   instr_pc_q, instr_pc_d;
    logic          kill_q, kill_d;
    logic          fetch_err_q, fetch_err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [31:0]   redirect_pc;

    assign redirect_pc = redirect_addr & ~32'h3;
    assign cnt_inc     = cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        kill_d      = kill_q;
        fetch_err_d = fetch_err_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_valid) fetch_pc_d = redirect_pc;
            end
            S_REQ: begin
                if (redirect_valid) fetch_pc_d = redirect_pc;
                if (imem_gnt) begin
                    state_d  = S_WAIT;
                    req_pc_d = fetch_pc_q;
                    kill_d   = redirect_valid;
                    cnt_d    = '0;
                end
            end
            S_WAIT: begin
                if (redirect_valid) fetch_pc_d = redirect_pc;
                if (imem_rvalid) begin
                    kill_d = 1'b0;
                    if (kill_q || redirect_valid) begin
                        state_d = S_REQ;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = req_pc_q;
                        state_d    = S_HOLD;
                    end
                end else begin
                    // a redirect with nothing returned yet poisons the in-flight response
                    if (redirect_valid) kill_d = 1'b1;
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(TIMEOUT)) begin
                        state_d     = S_ERR;
                        fetch_err_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = S_REQ;
                end else if (instr_ready) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = S_REQ;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= RESET_PC;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            kill_q      <= 1'b0;
            fetch_err_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            kill_q      <= kill_d;
            fetch_err_q <= fetch_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (state_q == S_HOLD);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_err   = fetch_err_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized and directed checks of fetch_ctrl against a transaction-level model
module tb_fetch_ctrl;
    localparam logic [31:0] RESET_PC = 32'h1000;
    localparam int          TIMEOUT  = 16;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the fetcher is booting, has a request in flight, holds an instruction,
    // is dead after a timeout, or otherwise is asking memory for m_pc.
    logic        m_boot, m_err, m_inflight, m_stale, m_hold;
    logic [31:0] m_pc, m_inflight_pc, m_instr, m_instr_pc;
    int          m_waits;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_boot = 1'b1; m_err = 1'b0; m_inflight = 1'b0; m_stale = 1'b0; m_hold = 1'b0;
            m_pc = RESET_PC; m_inflight_pc = RESET_PC; m_instr = '0; m_instr_pc = '0; m_waits = 0;
        end else if (m_err) begin
            m_err = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0;
            if (redirect_valid) m_pc = {redirect_addr[31:2], 2'b00};
        end else if (m_hold) begin
            if (redirect_valid) begin
                m_hold = 1'b0;
                m_pc = {redirect_addr[31:2], 2'b00};
            end else if (instr_ready) begin
                m_hold = 1'b0;
                m_pc = m_pc + 32'd4;
            end
        end else if (m_inflight) begin
            if (imem_rvalid) begin
                m_inflight = 1'b0;
                if (!(m_stale || redirect_valid)) begin
                    m_hold = 1'b1;
                    m_instr = imem_rdata;
                    m_instr_pc = m_inflight_pc;
                end
                m_stale = 1'b0;
            end else begin
                if (redirect_valid) m_stale = 1'b1;
                m_waits++;
                if (m_waits >= TIMEOUT) m_err = 1'b1;
            end
            if (redirect_valid) m_pc = {redirect_addr[31:2], 2'b00};
        end else begin
            if (imem_gnt) begin
                m_inflight = 1'b1;
                m_inflight_pc = m_pc;
                m_stale = redirect_valid;
                m_waits = 0;
            end
            if (redirect_valid) m_pc = {redirect_addr[31:2], 2'b00};
        end
    end

    always @(negedge clk) begin
        logic exp_req;
        exp_req = !m_boot && !m_err && !m_inflight && !m_hold;
        chk("model_imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        chk("model_instr_valid", {31'b0, instr_valid}, {31'b0, m_hold && !m_err});
        chk("model_fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
        chk("model_instr", instr, m_instr);
        chk("model_instr_pc", instr_pc, m_instr_pc);
        if (exp_req) begin
            chk("model_imem_addr", imem_addr, m_pc);
            chk("addr_aligned", {30'b0, imem_addr[1:0]}, 32'h0);
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic set_in(input logic g, input logic rv, input logic [31:0] rd,
                          input logic rdy, input logic rdr, input logic [31:0] ra);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        instr_ready = rdy; redirect_valid = rdr; redirect_addr = ra;
    endtask

    int rv_pct;

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        repeat (3) tick;
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_fetch_err", {31'b0, fetch_err}, 32'h0);
        rst_n = 1'b1;
        chk("idle_no_req", {31'b0, imem_req}, 32'h0);
        tick;
        // basic fetch
        chk("basic_req", {31'b0, imem_req}, 32'h1);
        chk("basic_addr", imem_addr, 32'h1000);
        set_in(1, 0, 0, 0, 0, 0);
        tick;
        chk("basic_wait_no_req", {31'b0, imem_req}, 32'h0);
        set_in(0, 1, 32'h00000013, 1, 0, 0);
        tick;
        chk("basic_valid", {31'b0, instr_valid}, 32'h1);
        chk("basic_instr", instr, 32'h00000013);
        chk("basic_pc", instr_pc, 32'h1000);
        set_in(0, 0, 0, 1, 0, 0);
        tick;
        chk("basic_next_addr", imem_addr, 32'h1004);
        chk("basic_next_req", {31'b0, imem_req}, 32'h1);
        // backpressure
        set_in(1, 0, 0, 0, 0, 0);
        tick;
        set_in(0, 1, 32'hdeadbeef, 0, 0, 0);
        tick;
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'b0, instr_valid}, 32'h1);
            chk("bp_instr", instr, 32'hdeadbeef);
            chk("bp_pc", instr_pc, 32'h1004);
            chk("bp_no_req", {31'b0, imem_req}, 32'h0);
            tick;
        end
        set_in(0, 0, 0, 1, 0, 0);
        tick;
        chk("bp_resume_addr", imem_addr, 32'h1008);
        // redirect during WAIT
        set_in(1, 0, 0, 0, 0, 0);
        tick;
        set_in(0, 0, 0, 0, 1, 32'h2002);
        tick;
        set_in(0, 1, 32'h00000bad, 0, 0, 0);
        tick;
        chk("rdw_dropped", {31'b0, instr_valid}, 32'h0);
        chk("rdw_req", {31'b0, imem_req}, 32'h1);
        chk("rdw_addr", imem_addr, 32'h2000);
        set_in(1, 0, 0, 0, 0, 0);
        tick;
        set_in(0, 1, 32'h00000111, 0, 0, 0);
        tick;
        chk("rdw_pc", instr_pc, 32'h2000);
        chk("rdw_instr", instr, 32'h00000111);
        set_in(0, 0, 0, 1, 0, 0);
        tick;
        // redirect together with gnt
        chk("rdg_addr", imem_addr, 32'h2004);
        set_in(1, 0, 0, 0, 1, 32'h3000);
        tick;
        set_in(0, 1, 32'h00000222, 0, 0, 0);
        tick;
        chk("rdg_dropped", {31'b0, instr_valid}, 32'h0);
        chk("rdg_addr_new", imem_addr, 32'h3000);
        set_in(1, 0, 0, 0, 0, 0);
        tick;
        set_in(0, 1, 32'h00000333, 0, 0, 0);
        tick;
        chk("rdg_pc", instr_pc, 32'h3000);
        // redirect plus ready in HOLD
        set_in(0, 0, 0, 1, 1, 32'h4000);
        tick;
        chk("rdh_not_repeated", {31'b0, instr_valid}, 32'h0);
        chk("rdh_addr", imem_addr, 32'h4000);
        // timeout
        set_in(1, 0, 0, 0, 0, 0);
        tick;
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            chk("to_not_yet", {31'b0, fetch_err}, 32'h0);
            tick;
        end
        tick;
        chk("to_err", {31'b0, fetch_err}, 32'h1);
        set_in(1, 1, 32'h1, 1, 1, 32'h5000);
        repeat (3) begin
            tick;
            chk("err_sticky", {31'b0, fetch_err}, 32'h1);
            chk("err_no_req", {31'b0, imem_req}, 32'h0);
            chk("err_no_valid", {31'b0, instr_valid}, 32'h0);
        end
        set_in(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        tick;
        chk("rst2_err_clear", {31'b0, fetch_err}, 32'h0);
        rst_n = 1'b1;
        tick;
        chk("rst2_addr", imem_addr, 32'h1000);
        chk("rst2_req", {31'b0, imem_req}, 32'h1);
        // randomized traffic; every third block starves rvalid to provoke timeouts
        for (int blk = 0; blk < 15; blk++) begin
            rv_pct = (blk % 3 == 2) ? 4 : 50;
            for (int c = 0; c < 200; c++) begin
                set_in($urandom_range(99) < 60, $urandom_range(99) < rv_pct, $urandom,
                       $urandom_range(99) < 60, $urandom_range(99) < 10, $urandom);
                tick;
                if ((m_err && $urandom_range(9) == 0) || $urandom_range(299) == 0) begin
                    #2 rst_n = 1'b0;
                    tick;
                    rst_n = 1'b1;
                end
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h1000, SHALL be the first fetch address after reset.
REQ-002 Parameter TIMEOUT, default 16, SHALL be the maximum cycles in WAIT before an error is flagged.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction-memory request valid.
REQ-006 imem_addr  output  32  request address; always word-aligned.
REQ-007 imem_gnt  input  1  request accepted this cycle when imem_req=1.
REQ-008 imem_rvalid  input  1  read data valid for the oldest granted request.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 instr_valid  output  1  instruction offered to decode.
REQ-011 instr_ready  input  1  decode accepts the instruction when instr_valid=1.
REQ-012 instr  output  32  fetched instruction word.
REQ-013 instr_pc  output  32  address of instr.
REQ-014 redirect_valid  input  1  branch/jump/jalr target override.
REQ-015 redirect_addr  input  32  new fetch address; bits [1:0] ignored and treated as 0.
REQ-016 fetch_err  output  1  sticky memory-timeout flag.

Function
REQ-017 States SHALL be IDLE, REQ, WAIT, HOLD and ERR, with at most one outstanding memory request.
REQ-018 IDLE SHALL last exactly one cycle after reset release, then move to REQ.
REQ-019 REQ: imem_req=1 and imem_addr=fetch_pc; on imem_gnt, move to WAIT and capture req_pc=fetch_pc.
REQ-020 imem_req SHALL be 0 in every state except REQ.
REQ-021 WAIT: on imem_rvalid with kill=0, latch instr=imem_rdata and instr_pc=req_pc, then move to HOLD.
REQ-022 WAIT: on imem_rvalid with kill=1, discard the data, clear kill, and move to REQ.
REQ-023 HOLD: instr_valid=1 with instr and instr_pc stable; on instr_ready, fetch_pc+=4 (mod 2^32) and move to REQ.
REQ-024 Minimum latency SHALL be 3 cycles from REQ entry to instr_valid, given gnt in the first REQ cycle and rvalid the cycle after gnt.
REQ-025 redirect_valid SHALL take priority over sequential update in every state; fetch_pc <= {redirect_addr[31:2],2'b00}.
REQ-026 Redirect in REQ without gnt: stay in REQ; imem_addr shows the new address next cycle.
REQ-027 Redirect in REQ with gnt in the same cycle: move to WAIT with kill=1.
REQ-028 Redirect in WAIT: set kill=1; if imem_rvalid arrives in the same cycle, drop the data and move to REQ with kill=0.
REQ-029 Redirect in HOLD, with or without instr_ready: drop the instruction, instr_valid=0 next cycle, move to REQ.
REQ-030 Redirect in IDLE SHALL update fetch_pc; the IDLE-to-REQ transition is unchanged.
REQ-031 Timeout counter: cleared on WAIT entry, incremented each WAIT cycle without rvalid.
REQ-032 When the timeout counter reaches TIMEOUT: move to ERR and set fetch_err=1.
REQ-033 ERR SHALL hold imem_req=0, instr_valid=0 and fetch_err=1, ignore all inputs, and exit only through reset.
REQ-034 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-035 While rst_n=0: state=IDLE, fetch_pc=req_pc=RESET_PC, kill=0, counter=0, imem_req=0, instr_valid=0, instr=0, instr_pc=0, fetch_err=0.
REQ-036 Reset assertion mid-transaction SHALL abandon any outstanding request with no further outputs.

Verification
REQ-037 Basic fetch: gnt on the first REQ cycle, rvalid one cycle later with 32'h00000013, ready held high -> instr_valid in cycle 3 with instr_pc=0x1000; next imem_addr=0x1004.
REQ-038 Backpressure: instr_ready low for 5 cycles -> instr and instr_pc held constant and imem_req=0 throughout.
REQ-039 Redirect during WAIT to 0x2002 -> in-flight response dropped; next imem_addr=0x2000; first delivered instr_pc=0x2000.
REQ-040 Redirect with gnt in the same cycle -> one response discarded; no instr_valid for the old address.
REQ-041 No rvalid for 16 WAIT cycles -> fetch_err=1, imem_req stays 0; rst_n pulse restores imem_addr=0x1000.
REQ-042 Redirect plus instr_ready in HOLD -> instruction not re-presented; fetch resumes at the redirect target, not pc+4.
